// File: rtl/wb_stage_pkg.sv
// Shared definitions for the Light RV32I writeback stage.
// Provides default register-file widths, the load funct3 encodings,
// the writeback FSM state encoding and a load legality helper.
package wb_stage_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } wb_state_e;

    // True when the funct3 is a supported load and the offset is naturally
    // aligned for its access size.
    function automatic logic load_is_legal(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~offset[0];
            F3_LW:         ok = (offset == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment for the writeback stage.
// Selects the addressed byte/halfword of a raw dmem word and sign- or
// zero-extends it according to the load funct3.
// Ports:
//   funct3_i  load funct3 (LB/LH/LW/LBU/LHU)
//   offset_i  low two address bits of the load
//   word_i    raw aligned word from data memory
//   data_o    extended register write value
module load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            offset_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Only offsets 0 and 2 reach here for halfword loads.
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the Light RV32I pipeline.
// Accepts retiring instructions from MEM (valid/ready), waits for the dmem
// response on loads, aligns/extends load data and issues a registered
// single-cycle register file write. Flags misaligned loads and response
// timeouts with one-cycle pulses.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   i_MemValid/o_MemReady MEM-stage handshake
//   i_RdAddr, i_AluResult destination register and non-load result
//   i_IsLoad, i_LoadFunct3, i_ByteOffset  load descriptor
//   i_DmemRspValid/Data   data memory read response
//   o_RegWr*              register file write port
//   o_Retire, o_MisalignErr, o_BusErr  per-instruction event pulses
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = WB_ADDR_WIDTH,
    parameter int unsigned RSP_TIMEOUT = 16,
    parameter int unsigned TMO_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_MemValid,
    output logic                  o_MemReady,
    input  logic [ADDR_WIDTH-1:0] i_RdAddr,
    input  logic [DATA_WIDTH-1:0] i_AluResult,
    input  logic                  i_IsLoad,
    input  logic [2:0]            i_LoadFunct3,
    input  logic [1:0]            i_ByteOffset,
    input  logic                  i_DmemRspValid,
    input  logic [DATA_WIDTH-1:0] i_DmemRspData,
    output logic [ADDR_WIDTH-1:0] o_RegWrAddr,
    output logic [DATA_WIDTH-1:0] o_RegWrData,
    output logic                  o_RegWrEn,
    output logic                  o_Retire,
    output logic                  o_MisalignErr,
    output logic                  o_BusErr
);

    wb_state_e             state_q, state_d;
    logic [TMO_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  retire_q, retire_d;
    logic                  mis_q, mis_d;
    logic                  bus_q, bus_d;
    logic [DATA_WIDTH-1:0] load_data;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .funct3_i (f3_q),
        .offset_i (off_q),
        .word_i   (i_DmemRspData),
        .data_o   (load_data)
    );

    assign o_MemReady    = (state_q == ST_IDLE);
    assign o_RegWrAddr   = wr_addr_q;
    assign o_RegWrData   = wr_data_q;
    assign o_RegWrEn     = wr_en_q;
    assign o_Retire      = retire_q;
    assign o_MisalignErr = mis_q;
    assign o_BusErr      = bus_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        f3_d      = f3_q;
        off_d     = off_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        retire_d  = 1'b0;
        mis_d     = 1'b0;
        bus_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Responses seen while idle (including the accept cycle) are dropped.
                if (i_MemValid) begin
                    if (!i_IsLoad) begin
                        retire_d = 1'b1;
                        if (i_RdAddr != '0) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = i_RdAddr;
                            wr_data_d = i_AluResult;
                        end
                    end else if (!load_is_legal(i_LoadFunct3, i_ByteOffset)) begin
                        retire_d = 1'b1;
                        mis_d    = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RSP;
                        cnt_d   = '0;
                        rd_d    = i_RdAddr;
                        f3_d    = i_LoadFunct3;
                        off_d   = i_ByteOffset;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A response on the final counted cycle still beats the timeout.
                if (i_DmemRspValid) begin
                    retire_d = 1'b1;
                    state_d  = ST_IDLE;
                    if (rd_q != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = rd_q;
                        wr_data_d = load_data;
                    end
                end else if (cnt_q == TMO_WIDTH'(RSP_TIMEOUT)) begin
                    retire_d = 1'b1;
                    bus_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            retire_q  <= 1'b0;
            mis_q     <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            retire_q  <= retire_d;
            mis_q     <= mis_d;
            bus_q     <= bus_d;
        end
    end

endmodule
